k_and_s_datapath: RTL and testbench

Datapath for the K&S multicycle processor: instruction register, 5-bit program counter, 4×16 register bank, 16-bit ALU, flags register and instruction decoder. It sits between the control unit and the synchronous program/data RAM. It consumes the control strobes and returns `decoded_instruction` and the four registered flags.

---
 rtl/k_and_s_pkg.sv | 83 ++++++++
 rtl/k_and_s_datapath_if.sv | 36 +++
 rtl/k_and_s_register_bank.sv | 43 ++++
 rtl/k_and_s_datapath.sv | 119 +++++++++++
 tb/tb_k_and_s_datapath.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/k_and_s_pkg.sv
// Shared types and constants for the K&S multicycle datapath.
// Width constants, decoded-instruction enum, ALU encodings and the opcode decoder.
package k_and_s_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 5;
  localparam int NREGS     = 4;
  localparam int REG_SEL_W = 2;

  typedef enum logic [3:0] {
    I_NOP,
    I_LOAD,
    I_STORE,
    I_MOVE,
    I_ADD,
    I_SUB,
    I_AND,
    I_OR,
    I_BRANCH,
    I_BZERO,
    I_BNEG,
    I_BOV,
    I_BNOV,
    I_BNNEG,
    I_BNZERO,
    I_HALT
  } decoded_instruction_type;

  typedef enum logic [1:0] {
    ALU_OR  = 2'b00,
    ALU_ADD = 2'b01,
    ALU_SUB = 2'b10,
    ALU_AND = 2'b11
  } alu_op_t;

  typedef struct packed {
    logic zero;
    logic neg;
    logic unsigned_ovf;
    logic signed_ovf;
  } alu_flags_t;

  localparam logic [7:0] OP_BRANCH = 8'h01;
  localparam logic [7:0] OP_BZERO  = 8'h02;
  localparam logic [7:0] OP_BNEG   = 8'h03;
  localparam logic [7:0] OP_BOV    = 8'h05;
  localparam logic [7:0] OP_BNOV   = 8'h06;
  localparam logic [7:0] OP_BNNEG  = 8'h0A;
  localparam logic [7:0] OP_BNZERO = 8'h0B;
  localparam logic [7:0] OP_LOAD   = 8'h81;
  localparam logic [7:0] OP_STORE  = 8'h82;
  localparam logic [7:0] OP_MOVE   = 8'h91;
  localparam logic [7:0] OP_ADD    = 8'hA1;
  localparam logic [7:0] OP_SUB    = 8'hA2;
  localparam logic [7:0] OP_AND    = 8'hA3;
  localparam logic [7:0] OP_OR     = 8'hA4;
  localparam logic [7:0] OP_HALT   = 8'hFF;

  // Unlisted opcodes fall through to I_NOP so stray words are harmless.
  function automatic decoded_instruction_type decode_opcode(input logic [7:0] opcode);
    decoded_instruction_type dec;
    case (opcode)
      OP_BRANCH: dec = I_BRANCH;
      OP_BZERO:  dec = I_BZERO;
      OP_BNEG:   dec = I_BNEG;
      OP_BOV:    dec = I_BOV;
      OP_BNOV:   dec = I_BNOV;
      OP_BNNEG:  dec = I_BNNEG;
      OP_BNZERO: dec = I_BNZERO;
      OP_LOAD:   dec = I_LOAD;
      OP_STORE:  dec = I_STORE;
      OP_MOVE:   dec = I_MOVE;
      OP_ADD:    dec = I_ADD;
      OP_SUB:    dec = I_SUB;
      OP_AND:    dec = I_AND;
      OP_OR:     dec = I_OR;
      OP_HALT:   dec = I_HALT;
      default:   dec = I_NOP;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/k_and_s_datapath_if.sv
// Control-unit / RAM side of the K&S datapath: strobes in, decode and flags out.
interface k_and_s_datapath_if;
  import k_and_s_pkg::*;

  logic                    ir_enable;
  logic                    pc_enable;
  logic                    branch;
  logic                    addr_sel;
  logic                    c_sel;
  logic [1:0]              operation;
  logic                    write_reg_enable;
  logic                    flags_reg_enable;
  decoded_instruction_type decoded_instruction;
  logic                    zero_op;
  logic                    neg_op;
  logic                    unsigned_overflow;
  logic                    signed_overflow;
  logic [ADDR_W-1:0]       ram_addr;
  logic [DATA_W-1:0]       data_out;
  logic [DATA_W-1:0]       data_in;

  modport master (
    output ir_enable, pc_enable, branch, addr_sel, c_sel, operation,
           write_reg_enable, flags_reg_enable, data_in,
    input  decoded_instruction, zero_op, neg_op, unsigned_overflow,
           signed_overflow, ram_addr, data_out
  );

  modport slave (
    input  ir_enable, pc_enable, branch, addr_sel, c_sel, operation,
           write_reg_enable, flags_reg_enable, data_in,
    output decoded_instruction, zero_op, neg_op, unsigned_overflow,
           signed_overflow, ram_addr, data_out
  );

endinterface

// File: rtl/k_and_s_register_bank.sv
// 4x16 register bank: one synchronous write port, two combinational read ports.
module k_and_s_register_bank
  import k_and_s_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 write_enable,
  input  logic [REG_SEL_W-1:0] write_sel,
  input  logic [DATA_W-1:0]    write_data,
  input  logic [REG_SEL_W-1:0] a_sel,
  input  logic [REG_SEL_W-1:0] b_sel,
  output logic [DATA_W-1:0]    a_data,
  output logic [DATA_W-1:0]    b_data
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (write_enable) begin
      regs_d[write_sel] = write_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign a_data = regs_q[a_sel];
  assign b_data = regs_q[b_sel];

endmodule

// File: rtl/k_and_s_datapath.sv
// K&S datapath: IR, PC, register bank, ALU, flags register, decoder and RAM address mux.
module k_and_s_datapath
  import k_and_s_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  k_and_s_datapath_if.slave bus
);

  logic [DATA_W-1:0]       ir_q, ir_d;
  logic [ADDR_W-1:0]       pc_q, pc_d;
  alu_flags_t              flags_q, flags_d;
  decoded_instruction_type decoded;

  logic [REG_SEL_W-1:0]    dest_sel, a_sel, b_sel;
  logic [DATA_W-1:0]       a_data, b_data;
  logic [DATA_W-1:0]       write_data;

  logic [DATA_W:0]         sum_ext, diff_ext;
  logic [DATA_W-1:0]       alu_result;
  alu_flags_t              alu_flags;

  assign decoded = decode_opcode(ir_q[15:8]);

  // Operand fields move around per instruction class; ALU layout is the default.
  always_comb begin
    dest_sel = ir_q[5:4];
    a_sel    = ir_q[3:2];
    b_sel    = ir_q[1:0];
    case (decoded)
      I_LOAD:  dest_sel = ir_q[6:5];
      I_STORE: a_sel    = ir_q[6:5];
      I_MOVE: begin
        dest_sel = ir_q[3:2];
        a_sel    = ir_q[1:0];
        b_sel    = ir_q[1:0];
      end
      default: ;
    endcase
  end

  assign write_data = bus.c_sel ? alu_result : bus.data_in;

  k_and_s_register_bank u_register_bank (
    .clk          (clk),
    .rst_n        (rst_n),
    .write_enable (bus.write_reg_enable),
    .write_sel    (dest_sel),
    .write_data   (write_data),
    .a_sel        (a_sel),
    .b_sel        (b_sel),
    .a_data       (a_data),
    .b_data       (b_data)
  );

  // The extra top bit of diff_ext is the borrow, i.e. A < B unsigned.
  always_comb begin
    sum_ext    = {1'b0, a_data} + {1'b0, b_data};
    diff_ext   = {1'b0, a_data} - {1'b0, b_data};
    alu_result = '0;
    alu_flags  = '0;
    case (alu_op_t'(bus.operation))
      ALU_OR:  alu_result = a_data | b_data;
      ALU_AND: alu_result = a_data & b_data;
      ALU_ADD: begin
        alu_result             = sum_ext[DATA_W-1:0];
        alu_flags.unsigned_ovf = sum_ext[DATA_W];
        alu_flags.signed_ovf   = (a_data[DATA_W-1] == b_data[DATA_W-1]) &&
                                 (alu_result[DATA_W-1] != a_data[DATA_W-1]);
      end
      ALU_SUB: begin
        alu_result             = diff_ext[DATA_W-1:0];
        alu_flags.unsigned_ovf = diff_ext[DATA_W];
        alu_flags.signed_ovf   = (a_data[DATA_W-1] != b_data[DATA_W-1]) &&
                                 (alu_result[DATA_W-1] != a_data[DATA_W-1]);
      end
      default: ;
    endcase
    alu_flags.zero = (alu_result == '0);
    alu_flags.neg  = alu_result[DATA_W-1];
  end

  // Branch target comes from the IR still held this cycle, even if IR reloads too.
  always_comb begin
    ir_d    = ir_q;
    pc_d    = pc_q;
    flags_d = flags_q;
    if (bus.ir_enable) begin
      ir_d = bus.data_in;
    end
    if (bus.pc_enable) begin
      pc_d = bus.branch ? ir_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
    end
    if (bus.flags_reg_enable) begin
      flags_d = alu_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q    <= '0;
      pc_q    <= '0;
      flags_q <= '0;
    end else begin
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
    end
  end

  assign bus.decoded_instruction = decoded;
  assign bus.ram_addr            = bus.addr_sel ? ir_q[ADDR_W-1:0] : pc_q;
  assign bus.data_out            = a_data;
  assign bus.zero_op             = flags_q.zero;
  assign bus.neg_op              = flags_q.neg;
  assign bus.unsigned_overflow   = flags_q.unsigned_ovf;
  assign bus.signed_overflow     = flags_q.signed_ovf;

endmodule

// File: tb/tb_k_and_s_datapath.sv
// Bench for k_and_s_datapath: acts as control unit and RAM, checks a vector table
// through an expectation queue, then exercises asynchronous reset mid-instruction.
module tb_k_and_s_datapath;
  import k_and_s_pkg::*;

  logic clk;
  logic rst_n;

  k_and_s_datapath_if bus();

  k_and_s_datapath dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic                    ir_en;
    logic                    pc_en;
    logic                    br;
    logic                    asel;
    logic                    csel;
    logic [1:0]              op;
    logic                    wr;
    logic                    fl;
    logic [15:0]             din;
    logic [4:0]              exp_addr;
    decoded_instruction_type exp_dec;
    logic [3:0]              exp_flags;
    logic                    chk_do;
    logic [15:0]             exp_do;
  } vec_t;

  typedef struct packed {
    logic [15:0]             idx;
    logic [4:0]              exp_addr;
    decoded_instruction_type exp_dec;
    logic [3:0]              exp_flags;
    logic                    chk_do;
    logic [15:0]             exp_do;
  } exp_t;

  vec_t vecs[$];
  exp_t expq[$];
  int   checks;
  int   errors;

  function automatic vec_t mk(input logic ir_en, input logic pc_en, input logic br,
                              input logic asel, input logic csel, input logic [1:0] op,
                              input logic wr, input logic fl, input logic [15:0] din,
                              input logic [4:0] exp_addr, input decoded_instruction_type exp_dec,
                              input logic [3:0] exp_flags, input logic chk_do,
                              input logic [15:0] exp_do);
    vec_t v;
    v.ir_en = ir_en; v.pc_en = pc_en; v.br = br; v.asel = asel; v.csel = csel;
    v.op = op; v.wr = wr; v.fl = fl; v.din = din; v.exp_addr = exp_addr;
    v.exp_dec = exp_dec; v.exp_flags = exp_flags; v.chk_do = chk_do; v.exp_do = exp_do;
    return v;
  endfunction

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic driveStrobes(input vec_t v);
    bus.ir_enable        = v.ir_en;
    bus.pc_enable        = v.pc_en;
    bus.branch           = v.br;
    bus.addr_sel         = v.asel;
    bus.c_sel            = v.csel;
    bus.operation        = v.op;
    bus.write_reg_enable = v.wr;
    bus.flags_reg_enable = v.fl;
    bus.data_in          = v.din;
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    exp_t e;
    @(negedge clk);
    driveStrobes(v);
    e.idx = 16'(idx); e.exp_addr = v.exp_addr; e.exp_dec = v.exp_dec;
    e.exp_flags = v.exp_flags; e.chk_do = v.chk_do; e.exp_do = v.exp_do;
    expq.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    @(posedge clk);
    #1;
    if (expq.size() == 0) begin
      checkValue("scoreboard empty", 32'd0, 32'd1);
      return;
    end
    e = expq.pop_front();
    checkValue($sformatf("v%0d ram_addr", e.idx), 32'(bus.ram_addr), 32'(e.exp_addr));
    checkValue($sformatf("v%0d decoded", e.idx), 32'(bus.decoded_instruction), 32'(e.exp_dec));
    checkValue($sformatf("v%0d flags{z,n,u,s}", e.idx),
               {28'd0, bus.zero_op, bus.neg_op, bus.unsigned_overflow, bus.signed_overflow},
               32'(e.exp_flags));
    if (e.chk_do) begin
      checkValue($sformatf("v%0d data_out", e.idx), 32'(bus.data_out), 32'(e.exp_do));
    end
  endtask

  task automatic runVector(input int idx, input vec_t v);
    applyStimulus(idx, v);
    checkOutput();
  endtask

  task automatic checkAllClear(input string tag);
    checkValue({tag, " ram_addr"}, 32'(bus.ram_addr), 32'd0);
    checkValue({tag, " decoded"}, 32'(bus.decoded_instruction), 32'(I_NOP));
    checkValue({tag, " data_out"}, 32'(bus.data_out), 32'd0);
    checkValue({tag, " flags"},
               {28'd0, bus.zero_op, bus.neg_op, bus.unsigned_overflow, bus.signed_overflow},
               32'd0);
  endtask

  initial begin
    vec_t idle;
    checks = 0;
    errors = 0;
    idle   = '0;
    rst_n  = 1'b0;
    driveStrobes(idle);

    // Columns: ir_en pc_en br asel csel op wr fl din | addr dec flags chk_do data_out
    vecs.push_back(mk(1,0,0,0,0,2'b00,0,0,16'h8140, 5'd0,  I_LOAD,  4'b0000,0,16'h0));
    vecs.push_back(mk(0,0,0,0,0,2'b00,1,0,16'h7FFF, 5'd0,  I_LOAD,  4'b0000,0,16'h0));
    vecs.push_back(mk(1,0,0,0,0,2'b00,0,0,16'h8160, 5'd0,  I_LOAD,  4'b0000,0,16'h0));
    vecs.push_back(mk(0,0,0,0,0,2'b00,1,0,16'h0001, 5'd0,  I_LOAD,  4'b0000,0,16'h0));
    vecs.push_back(mk(1,0,0,0,0,2'b00,0,0,16'hA11B, 5'd0,  I_ADD,   4'b0000,1,16'h7FFF));
    vecs.push_back(mk(0,0,0,0,1,2'b01,1,1,16'h0000, 5'd0,  I_ADD,   4'b0101,1,16'h7FFF));
    vecs.push_back(mk(1,0,0,1,0,2'b00,0,0,16'h8225, 5'd5,  I_STORE, 4'b0101,1,16'h8000));
    vecs.push_back(mk(1,0,0,0,0,2'b00,0,0,16'h8140, 5'd0,  I_LOAD,  4'b0101,0,16'h0));
    vecs.push_back(mk(0,0,0,0,0,2'b00,1,0,16'h0005, 5'd0,  I_LOAD,  4'b0101,0,16'h0));
    vecs.push_back(mk(1,0,0,0,0,2'b00,0,0,16'h8160, 5'd0,  I_LOAD,  4'b0101,0,16'h0));
    vecs.push_back(mk(0,0,0,0,0,2'b00,1,0,16'h0005, 5'd0,  I_LOAD,  4'b0101,0,16'h0));
    vecs.push_back(mk(1,0,0,0,0,2'b00,0,0,16'hA21B, 5'd0,  I_SUB,   4'b0101,1,16'h0005));
    vecs.push_back(mk(0,0,0,0,1,2'b10,1,1,16'h0000, 5'd0,  I_SUB,   4'b1000,1,16'h0005));
    vecs.push_back(mk(1,0,0,1,0,2'b00,0,0,16'h8225, 5'd5,  I_STORE, 4'b1000,1,16'h0000));
    vecs.push_back(mk(1,0,0,0,0,2'b00,0,0,16'h8140, 5'd0,  I_LOAD,  4'b1000,0,16'h0));
    vecs.push_back(mk(0,0,0,0,0,2'b00,1,0,16'h0000, 5'd0,  I_LOAD,  4'b1000,0,16'h0));
    vecs.push_back(mk(1,0,0,0,0,2'b00,0,0,16'h8160, 5'd0,  I_LOAD,  4'b1000,0,16'h0));
    vecs.push_back(mk(0,0,0,0,0,2'b00,1,0,16'h0001, 5'd0,  I_LOAD,  4'b1000,0,16'h0));
    vecs.push_back(mk(1,0,0,0,0,2'b00,0,0,16'hA21B, 5'd0,  I_SUB,   4'b1000,1,16'h0000));
    vecs.push_back(mk(0,0,0,0,1,2'b10,1,1,16'h0000, 5'd0,  I_SUB,   4'b0110,1,16'h0000));
    vecs.push_back(mk(1,0,0,1,0,2'b00,0,0,16'h8225, 5'd5,  I_STORE, 4'b0110,1,16'hFFFF));
    vecs.push_back(mk(1,0,0,0,0,2'b00,0,0,16'h0105, 5'd0,  I_BRANCH,4'b0110,0,16'h0));
    vecs.push_back(mk(0,1,1,0,0,2'b00,0,0,16'h0000, 5'd5,  I_BRANCH,4'b0110,0,16'h0));
    vecs.push_back(mk(0,1,0,0,0,2'b00,0,0,16'h0000, 5'd6,  I_BRANCH,4'b0110,0,16'h0));
    vecs.push_back(mk(1,0,0,0,0,2'b00,0,0,16'h011F, 5'd6,  I_BRANCH,4'b0110,0,16'h0));
    vecs.push_back(mk(0,1,1,0,0,2'b00,0,0,16'h0000, 5'd31, I_BRANCH,4'b0110,0,16'h0));
    vecs.push_back(mk(0,1,0,0,0,2'b00,0,0,16'h0000, 5'd0,  I_BRANCH,4'b0110,0,16'h0));
    vecs.push_back(mk(1,1,1,0,0,2'b00,0,0,16'h0105, 5'd31, I_BRANCH,4'b0110,0,16'h0));
    vecs.push_back(mk(1,1,0,0,0,2'b00,0,0,16'h011F, 5'd0,  I_BRANCH,4'b0110,0,16'h0));
    vecs.push_back(mk(0,1,1,0,0,2'b00,0,0,16'h0000, 5'd31, I_BRANCH,4'b0110,0,16'h0));
    vecs.push_back(mk(1,0,0,0,0,2'b00,0,0,16'h8165, 5'd31, I_LOAD,  4'b0110,0,16'h0));
    vecs.push_back(mk(0,0,0,1,0,2'b00,0,0,16'h0000, 5'd5,  I_LOAD,  4'b0110,0,16'h0));
    vecs.push_back(mk(0,0,0,0,0,2'b00,1,0,16'h1234, 5'd31, I_LOAD,  4'b0110,0,16'h0));
    vecs.push_back(mk(1,0,0,1,0,2'b00,0,0,16'h8265, 5'd5,  I_STORE, 4'b0110,1,16'h1234));
    vecs.push_back(mk(1,0,0,0,0,2'b00,0,0,16'h8160, 5'd31, I_LOAD,  4'b0110,0,16'h0));
    vecs.push_back(mk(0,0,0,0,0,2'b00,1,0,16'h8001, 5'd31, I_LOAD,  4'b0110,0,16'h0));
    vecs.push_back(mk(1,0,0,0,0,2'b00,0,0,16'h910B, 5'd31, I_MOVE,  4'b0110,1,16'h8001));
    vecs.push_back(mk(0,0,0,0,1,2'b00,1,1,16'h0000, 5'd31, I_MOVE,  4'b0100,1,16'h8001));
    vecs.push_back(mk(1,0,0,1,0,2'b00,0,0,16'h8245, 5'd5,  I_STORE, 4'b0100,1,16'h8001));
    vecs.push_back(mk(1,0,0,0,0,2'b00,0,0,16'h5500, 5'd31, I_NOP,   4'b0100,0,16'h0));
    vecs.push_back(mk(0,0,0,0,0,2'b00,0,0,16'h0000, 5'd31, I_NOP,   4'b0100,0,16'h0));
    vecs.push_back(mk(1,0,0,0,0,2'b00,0,0,16'hA30C, 5'd31, I_AND,   4'b0100,1,16'h8001));
    vecs.push_back(mk(0,0,0,0,1,2'b11,1,1,16'h0000, 5'd31, I_AND,   4'b1000,1,16'h8001));
    vecs.push_back(mk(1,0,0,1,0,2'b00,0,0,16'h8205, 5'd5,  I_STORE, 4'b1000,1,16'h0000));
    vecs.push_back(mk(1,0,0,0,0,2'b00,0,0,16'hFF00, 5'd31, I_HALT,  4'b1000,0,16'h0));
    vecs.push_back(mk(1,0,0,0,0,2'b00,0,0,16'hA400, 5'd31, I_OR,    4'b1000,0,16'h0));
    vecs.push_back(mk(1,0,0,0,0,2'b00,0,0,16'h0200, 5'd31, I_BZERO, 4'b1000,0,16'h0));
    vecs.push_back(mk(1,0,0,0,0,2'b00,0,0,16'h0300, 5'd31, I_BNEG,  4'b1000,0,16'h0));
    vecs.push_back(mk(1,0,0,0,0,2'b00,0,0,16'h0500, 5'd31, I_BOV,   4'b1000,0,16'h0));
    vecs.push_back(mk(1,0,0,0,0,2'b00,0,0,16'h0600, 5'd31, I_BNOV,  4'b1000,0,16'h0));
    vecs.push_back(mk(1,0,0,0,0,2'b00,0,0,16'h0A00, 5'd31, I_BNNEG, 4'b1000,0,16'h0));
    vecs.push_back(mk(1,0,0,0,0,2'b00,0,0,16'h0B00, 5'd31, I_BNZERO,4'b1000,0,16'h0));
    vecs.push_back(mk(1,0,0,0,0,2'b00,0,0,16'h0400, 5'd31, I_NOP,   4'b1000,0,16'h0));
    vecs.push_back(mk(1,0,0,0,0,2'b00,0,0,16'h8300, 5'd31, I_NOP,   4'b1000,0,16'h0));
    vecs.push_back(mk(1,0,0,0,0,2'b00,0,0,16'h8100, 5'd31, I_LOAD,  4'b1000,0,16'h0));
    vecs.push_back(mk(0,0,0,0,0,2'b00,1,0,16'hBEEF, 5'd31, I_LOAD,  4'b1000,0,16'h0));
    vecs.push_back(mk(1,0,0,0,0,2'b00,0,0,16'hA11B, 5'd31, I_ADD,   4'b1000,1,16'h8001));

    #12;
    checkAllClear("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      runVector(i, vecs[i]);
    end

    // Asynchronous reset in the middle of a fetch with a register write pending.
    @(negedge clk);
    bus.ir_enable        = 1'b1;
    bus.data_in          = 16'h8225;
    bus.write_reg_enable = 1'b1;
    bus.c_sel            = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkAllClear("midreset");
    @(posedge clk);
    @(posedge clk);
    #1;
    checkAllClear("heldreset");
    @(negedge clk);
    driveStrobes(idle);
    rst_n = 1'b1;

    runVector(100, mk(1,0,0,1,0,2'b00,0,0,16'h8205, 5'd5, I_STORE, 4'b0000,1,16'h0000));
    runVector(101, mk(1,0,0,1,0,2'b00,0,0,16'h8225, 5'd5, I_STORE, 4'b0000,1,16'h0000));
    runVector(102, mk(1,0,0,1,0,2'b00,0,0,16'h8245, 5'd5, I_STORE, 4'b0000,1,16'h0000));
    runVector(103, mk(1,0,0,0,0,2'b00,0,0,16'h8265, 5'd0, I_STORE, 4'b0000,1,16'h0000));

    checkValue("scoreboard drained", 32'(expq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
